// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing counters, active-region syncs and delayed active-low physical syncs.
// Define VGA_TEST_PATTERN_EN to add an 8-bar colour test pattern aligned with the physical syncs.
module vga_sync_gen #(
  parameter int c_TOTAL_COLS    = 800,
  parameter int c_TOTAL_ROWS    = 525,
  parameter int c_ACTIVE_COLS   = 640,
  parameter int c_ACTIVE_ROWS   = 480,
  parameter int c_H_FRONT_PORCH = 16,
  parameter int c_H_SYNC_WIDTH  = 96,
  parameter int c_V_FRONT_PORCH = 10,
  parameter int c_V_SYNC_WIDTH  = 2,
  parameter int c_VIDEO_DELAY   = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic       o_Line_Start,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [3:0] o_Red_Video,
  output logic [3:0] o_Grn_Video,
  output logic [3:0] o_Blu_Video
`endif
);
  localparam logic [9:0]  LAST_COL = 10'(c_TOTAL_COLS - 1);
  localparam logic [9:0]  LAST_ROW = 10'(c_TOTAL_ROWS - 1);
  localparam logic [10:0] ACT_C    = 11'(c_ACTIVE_COLS);
  localparam logic [10:0] ACT_R    = 11'(c_ACTIVE_ROWS);
  localparam logic [10:0] HS_BEG   = 11'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
  localparam logic [10:0] HS_END   = 11'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH);
  localparam logic [10:0] VS_BEG   = 11'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
  localparam logic [10:0] VS_END   = 11'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH);
  logic [9:0] col_q, col_d, row_q, row_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, frame_q, frame_d, line_q, line_d;
  logic [c_VIDEO_DELAY:0] vh_q, vh_d, vv_q, vv_d;
`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(c_ACTIVE_COLS / 8);
  logic [2:0] bar;
  logic [c_VIDEO_DELAY:0][11:0] rgb_q, rgb_d;
`endif
  // Stage 0 of each pipeline is aligned with the counters; stage c_VIDEO_DELAY drives the pins.
  always_comb begin
    col_d = col_q == LAST_COL ? 10'd0 : col_q + 10'd1;
    row_d = col_q != LAST_COL ? row_q : row_q == LAST_ROW ? 10'd0 : row_q + 10'd1;
    hsync_d = 11'(col_d) < ACT_C;
    vsync_d = 11'(row_d) < ACT_R;
    line_d = col_d == 10'd0;
    frame_d = line_d && row_d == 10'd0;
    vh_d[0] = !(11'(col_d) >= HS_BEG && 11'(col_d) < HS_END);
    vv_d[0] = !(11'(row_d) >= VS_BEG && 11'(row_d) < VS_END);
    for (int i = 1; i <= c_VIDEO_DELAY; i++) begin
      vh_d[i] = vh_q[i-1];
      vv_d[i] = vv_q[i-1];
    end
`ifdef VGA_TEST_PATTERN_EN
    bar = 3'(col_d / BAR_W);
    rgb_d[0] = hsync_d && vsync_d ? {{4{bar[0]}}, {4{bar[1]}}, {4{bar[2]}}} : 12'd0;
    for (int i = 1; i <= c_VIDEO_DELAY; i++) rgb_d[i] = rgb_q[i-1];
`endif
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      col_q   <= LAST_COL;
      row_q   <= LAST_ROW;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
      vh_q    <= '1;
      vv_q    <= '1;
`ifdef VGA_TEST_PATTERN_EN
      rgb_q   <= '0;
`endif
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      frame_q <= frame_d;
      line_q  <= line_d;
      vh_q    <= vh_d;
      vv_q    <= vv_d;
`ifdef VGA_TEST_PATTERN_EN
      rgb_q   <= rgb_d;
`endif
    end
  end
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Frame_Start = frame_q;
  assign o_Line_Start  = line_q;
  assign o_VGA_HSync   = vh_q[c_VIDEO_DELAY];
  assign o_VGA_VSync   = vv_q[c_VIDEO_DELAY];
`ifdef VGA_TEST_PATTERN_EN
  assign {o_Red_Video, o_Grn_Video, o_Blu_Video} = rgb_q[c_VIDEO_DELAY];
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized self-checking bench; expected outputs derived arithmetically from elapsed clocks since reset release.
module tb_vga_sync_gen;
  localparam int TC = 100, TR = 40, AC = 64, AR = 24, HFP = 8, HSW = 12, VFP = 3, VSW = 2, D = 2;
  localparam int FRAME = TC * TR;
  logic clk = 1'b0, rst = 1'b1;
  logic hs, vs, fs, ls, vh, vv;
  logic [9:0] col, row;
  logic [25:0] obs;
  int t = -1, checks = 0, passed = 0;
`ifdef VGA_TEST_PATTERN_EN
  logic [3:0] red, grn, blu;
`endif
  always #5 clk = ~clk;
  vga_sync_gen #(
    .c_TOTAL_COLS(TC), .c_TOTAL_ROWS(TR), .c_ACTIVE_COLS(AC), .c_ACTIVE_ROWS(AR),
    .c_H_FRONT_PORCH(HFP), .c_H_SYNC_WIDTH(HSW), .c_V_FRONT_PORCH(VFP),
    .c_V_SYNC_WIDTH(VSW), .c_VIDEO_DELAY(D)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .o_HSync(hs), .o_VSync(vs),
    .o_Col_Count(col), .o_Row_Count(row), .o_Frame_Start(fs), .o_Line_Start(ls),
    .o_VGA_HSync(vh), .o_VGA_VSync(vv)
`ifdef VGA_TEST_PATTERN_EN
    , .o_Red_Video(red), .o_Grn_Video(grn), .o_Blu_Video(blu)
`endif
  );
  assign obs = {hs, vs, fs, ls, vh, vv, col, row};
  // k = clocks since the first released edge (k<0: in reset)
  function automatic logic [25:0] model(int k);
    int c, r, kd, cd, rd;
    logic ph, pv;
    if (k < 0) return {6'b000011, 10'(TC - 1), 10'(TR - 1)};
    c = k % TC;
    r = (k / TC) % TR;
    kd = k - D;
    cd = kd < 0 ? 0 : kd % TC;
    rd = kd < 0 ? 0 : (kd / TC) % TR;
    ph = kd < 0 || cd < AC + HFP || cd >= AC + HFP + HSW;
    pv = kd < 0 || rd < AR + VFP || rd >= AR + VFP + VSW;
    return {c < AC, r < AR, k % FRAME == 0, c == 0, ph, pv, 10'(c), 10'(r)};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    t = rst ? -1 : t + 1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (5) begin
      step();
      checks++;
      if (obs !== model(-1)) $display("FAIL reset_state: got %h want %h", obs, model(-1));
      else passed++;
    end
    rst = 1'b0;
    step();
    checks++;
    if (obs !== model(0)) $display("FAIL first_release: got %h want %h", obs, model(0));
    else passed++;
    step();
    checks++;
    if (col !== 10'd1 || fs !== 1'b0) $display("FAIL second_cycle: got col=%0d fs=%b want col=1 fs=0", col, fs);
    else passed++;
  endtask
  task automatic test_line();
    int hi = 0, starts = 0;
    repeat (TC) begin
      step();
      hi += int'(hs);
      starts += int'(ls);
      checks++;
      if (obs !== model(t)) $display("FAIL line t=%0d: got %h want %h", t, obs, model(t));
      else passed++;
    end
    checks++;
    if (hi != AC || starts != 1) $display("FAIL line_counts: got hs_high=%0d line_starts=%0d want %0d/1", hi, starts, AC);
    else passed++;
  endtask
  task automatic test_frames();
    int vlow = 0, last_fs = -1, nfs = 0;
    repeat (2 * FRAME) begin
      step();
      vlow += int'(!vv);
      if (fs) begin
        checks++;
        if (last_fs >= 0 && t - last_fs != FRAME) $display("FAIL frame_spacing: got %0d want %0d", t - last_fs, FRAME);
        else passed++;
        last_fs = t;
        nfs++;
      end
      checks++;
      if (obs !== model(t)) $display("FAIL frames t=%0d: got %h want %h", t, obs, model(t));
      else passed++;
    end
    checks++;
    if (vlow != 2 * VSW * TC || nfs != 2) $display("FAIL vsync_low: got low=%0d frames=%0d want %0d/2", vlow, nfs, 2 * VSW * TC);
    else passed++;
  endtask
  task automatic test_mid_reset();
    int run, hold;
    repeat (4) begin
      run = int'($urandom_range(1, FRAME));
      hold = int'($urandom_range(1, 3));
      repeat (run) begin
        step();
        checks++;
        if (obs !== model(t)) $display("FAIL pre_reset t=%0d: got %h want %h", t, obs, model(t));
        else passed++;
      end
      rst = 1'b1;
      repeat (hold) begin
        step();
        checks++;
        if (obs !== model(-1)) $display("FAIL mid_reset: got %h want %h", obs, model(-1));
        else passed++;
      end
      rst = 1'b0;
      repeat (D + 4) begin
        step();
        checks++;
        if (obs !== model(t)) $display("FAIL post_reset t=%0d: got %h want %h", t, obs, model(t));
        else passed++;
      end
    end
  endtask
`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int c, kd, b;
    logic [11:0] want;
    repeat (2 * TC) begin
      step();
      kd = t - D;
      c = kd % TC;
      b = c / (AC / 8);
      want = (kd < 0 || c >= AC || (kd / TC) % TR >= AR) ? 12'd0 :
             {{4{b[0]}}, {4{b[1]}}, {4{b[2]}}};
      checks++;
      if ({red, grn, blu} !== want) $display("FAIL pattern t=%0d: got %h want %h", t, {red, grn, blu}, want);
      else passed++;
    end
  endtask
`endif
  initial begin
    test_reset();
    test_line();
    test_frames();
    test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
